// File: rtl/lz77_pkg.sv
// Shared definitions for the LZ77 code sequencer.
//   Widths of the {pos,len,char} code word, the code memory address width,
//   the terminating literal, the packed code word layout and the FSM states.
package lz77_pkg;

  localparam int unsigned POS_W  = 4;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned CHAR_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam logic [CHAR_W-1:0] END_CHAR = 8'h24;

  // Layout of one code memory word, MSB first: {pos, len, char}.
  typedef struct packed {
    logic [POS_W-1:0]  pos;
    logic [LEN_W-1:0]  len;
    logic [CHAR_W-1:0] chr;
  } code_word_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    RUN,
    DONE
  } seq_state_e;

endpackage

// File: rtl/lz77_code_prefetch_buf.sv
// One-entry holding register for a prefetched code word.
// Only compiled when LZ77_SEQ_PREFETCH_EN is defined; the default build has
// no buffer at all.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_wr, i_wdata  : capture a returned code word
//   i_clr          : consume / flush the entry (wins over i_wr)
//   o_valid, o_data: entry state and contents
`ifdef LZ77_SEQ_PREFETCH_EN
module lz77_code_prefetch_buf #(
  parameter int unsigned W = 15
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_clr,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_wr) begin
      r_valid <= 1'b1;
      r_data  <= i_wdata;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`endif

// File: rtl/lz77_code_sequencer.sv
// Feeds {pos,len,char} code words from a 1-cycle-latency code memory to the
// LZ77 decoder. Each word is held on dec_* for len+1 enabled cycles; dec_en
// follows out_ready while running. Stops after the END_CHAR word, or flags
// err_wrap when the address wraps without one.
// Optional zero-bubble prefetch: define LZ77_SEQ_PREFETCH_EN.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   start, start_addr    : begin decoding at start_addr (IDLE/DONE only)
//   code_rd, code_addr   : code memory read strobe / address
//   code_rdata           : {pos,len,char}, valid the cycle after code_rd
//   out_ready            : downstream accepts a char this cycle
//   dec_en               : decoder advances one char this cycle
//   dec_pos/len/char     : held code word
//   busy, done           : activity flag, 1-cycle completion pulse
//   err_wrap, word_cnt   : sticky wrap error, words completed since start
module lz77_code_sequencer #(
  parameter int unsigned       POS_W    = lz77_pkg::POS_W,
  parameter int unsigned       LEN_W    = lz77_pkg::LEN_W,
  parameter int unsigned       CHAR_W   = lz77_pkg::CHAR_W,
  parameter int unsigned       ADDR_W   = lz77_pkg::ADDR_W,
  parameter logic [CHAR_W-1:0] END_CHAR = lz77_pkg::END_CHAR
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [ADDR_W-1:0]               start_addr,
  output logic                            code_rd,
  output logic [ADDR_W-1:0]               code_addr,
  input  logic [POS_W+LEN_W+CHAR_W-1:0]   code_rdata,
  input  logic                            out_ready,
  output logic                            dec_en,
  output logic [POS_W-1:0]                dec_pos,
  output logic [LEN_W-1:0]                dec_len,
  output logic [CHAR_W-1:0]               dec_char,
  output logic                            busy,
  output logic                            done,
  output logic                            err_wrap,
  output logic [ADDR_W-1:0]               word_cnt
);
  import lz77_pkg::*;

  localparam int unsigned CW = POS_W + LEN_W + CHAR_W;

  seq_state_e          r_state;
  logic [ADDR_W-1:0]   r_addr, r_word_cnt;
  logic [LEN_W-1:0]    r_rem, r_len;
  logic [POS_W-1:0]    r_pos;
  logic [CHAR_W-1:0]   r_char;
  logic                r_code_rd, r_done, r_err_wrap, r_wrap;

  logic                w_run, w_final, w_addr_inc, w_addr_max, w_wrap_next;
  logic                w_next_valid, w_pf_inc, w_issue_ld, w_issue_nx;
  logic [CW-1:0]       w_next;
  logic [CHAR_W-1:0]   w_rd_char, w_nx_char;

  assign w_rd_char   = code_rdata[CHAR_W-1:0];
  assign w_nx_char   = w_next[CHAR_W-1:0];
  assign w_run       = (r_state == RUN);
  assign w_final     = w_run & out_ready & (r_rem == '0);
  assign w_addr_max  = (r_addr == '1);
  // addr moves on the cycle a read's data is consumed (LOAD, or prefetch arrival)
  assign w_addr_inc  = (r_state == LOAD) | w_pf_inc;
  assign w_wrap_next = r_wrap | (w_addr_inc & w_addr_max);

`ifdef LZ77_SEQ_PREFETCH_EN
  logic          r_pf_pend;
  logic          w_buf_valid, w_buf_wr, w_buf_clr, w_start_ok;
  logic [CW-1:0] w_buf_data;

  assign w_start_ok = start & ((r_state == IDLE) | (r_state == DONE));
  // Data arriving on the final cycle bypasses the buffer straight into dec_*.
  assign w_buf_wr   = w_run & r_pf_pend & ~w_final;
  assign w_buf_clr  = (w_final & w_buf_valid) | w_start_ok;

  lz77_code_prefetch_buf #(.W(CW)) u_pf_buf (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_wr    (w_buf_wr),
    .i_wdata (code_rdata),
    .i_clr   (w_buf_clr),
    .o_valid (w_buf_valid),
    .o_data  (w_buf_data)
  );

  assign w_pf_inc     = w_run & r_pf_pend;
  assign w_next_valid = w_buf_valid | (w_run & r_pf_pend);
  assign w_next       = w_buf_valid ? w_buf_data : code_rdata;
  assign w_issue_ld   = (w_rd_char != END_CHAR) & ~w_wrap_next;
  assign w_issue_nx   = (w_nx_char != END_CHAR) & ~w_wrap_next;
`else
  assign w_pf_inc     = 1'b0;
  assign w_next_valid = 1'b0;
  assign w_next       = '0;
  assign w_issue_ld   = 1'b0;
  assign w_issue_nx   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_pos      <= '0;
      r_len      <= '0;
      r_char     <= '0;
      r_code_rd  <= 1'b0;
      r_done     <= 1'b0;
      r_err_wrap <= 1'b0;
      r_wrap     <= 1'b0;
      r_word_cnt <= '0;
`ifdef LZ77_SEQ_PREFETCH_EN
      r_pf_pend  <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_code_rd <= 1'b0;
`ifdef LZ77_SEQ_PREFETCH_EN
      r_pf_pend <= r_code_rd & w_run;
`endif
      if (w_addr_inc) begin
        r_addr <= r_addr + 1'b1;
        if (w_addr_max) r_wrap <= 1'b1;
      end
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_addr     <= start_addr;
            r_word_cnt <= '0;
            r_err_wrap <= 1'b0;
            r_wrap     <= 1'b0;
            r_code_rd  <= 1'b1;
            r_state    <= FETCH;
          end
        end
        FETCH: r_state <= LOAD;
        LOAD: begin
          r_pos     <= code_rdata[CW-1 -: POS_W];
          r_len     <= code_rdata[LEN_W+CHAR_W-1 -: LEN_W];
          r_rem     <= code_rdata[LEN_W+CHAR_W-1 -: LEN_W];
          r_char    <= w_rd_char;
          r_code_rd <= w_issue_ld;
          r_state   <= RUN;
        end
        RUN: begin
          if (out_ready) begin
            if (r_rem != '0) begin
              r_rem <= r_rem - 1'b1;
            end else begin
              r_word_cnt <= r_word_cnt + 1'b1;
              if (w_next_valid) begin
                r_pos     <= w_next[CW-1 -: POS_W];
                r_len     <= w_next[LEN_W+CHAR_W-1 -: LEN_W];
                r_rem     <= w_next[LEN_W+CHAR_W-1 -: LEN_W];
                r_char    <= w_nx_char;
                r_code_rd <= w_issue_nx;
              end else if (r_code_rd) begin
                // len==0 word: its prefetch is still in flight, take one bubble
                r_state <= LOAD;
              end else if ((r_char == END_CHAR) || r_wrap) begin
                r_state <= DONE;
                r_done  <= 1'b1;
                if (r_char != END_CHAR) r_err_wrap <= 1'b1;
              end else begin
                r_code_rd <= 1'b1;
                r_state   <= FETCH;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // dec_en must respond to out_ready in the same cycle, so it is a gate on
  // the registered state rather than a register itself.
  assign dec_en    = w_run & out_ready;
  assign code_rd   = r_code_rd;
  assign code_addr = r_addr;
  assign dec_pos   = r_pos;
  assign dec_len   = r_len;
  assign dec_char  = r_char;
  assign busy      = (r_state == FETCH) | (r_state == LOAD) | (r_state == RUN);
  assign done      = r_done;
  assign err_wrap  = r_err_wrap;
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_lz77_code_sequencer.sv
// Scoreboard bench for lz77_code_sequencer (ADDR_W=2, 4-word code memory).
// Expected decoder words are queued per enabled cycle; a negedge monitor pops
// and compares whenever dec_en is high.
module tb_lz77_code_sequencer;
  import lz77_pkg::*;

  localparam int unsigned AW = 2;
  localparam int unsigned CW = POS_W + LEN_W + CHAR_W;
`ifdef LZ77_SEQ_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              clk_en = 1'b1;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              out_ready = 1'b1;
  logic [AW-1:0]     start_addr = '0;
  logic              code_rd;
  logic [AW-1:0]     code_addr;
  logic [CW-1:0]     code_rdata = '0;
  logic              dec_en;
  logic [POS_W-1:0]  dec_pos;
  logic [LEN_W-1:0]  dec_len;
  logic [CHAR_W-1:0] dec_char;
  logic              busy, done, err_wrap;
  logic [AW-1:0]     word_cnt;

  logic [CW-1:0] mem [4];
  logic [CW-1:0] exp_q [$];
  logic [CW-1:0] mon_w;
  int unsigned cyc = 0, t0 = 0;
  int unsigned en_first = 0, en_last = 0, en_cnt = 0, done_cnt = 0, rd_cnt = 0;
  int unsigned n_pass = 0, n_total = 0;

  lz77_code_sequencer #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .code_rd    (code_rd),
    .code_addr  (code_addr),
    .code_rdata (code_rdata),
    .out_ready  (out_ready),
    .dec_en     (dec_en),
    .dec_pos    (dec_pos),
    .dec_len    (dec_len),
    .dec_char   (dec_char),
    .busy       (busy),
    .done       (done),
    .err_wrap   (err_wrap),
    .word_cnt   (word_cnt)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // 1-cycle-latency memory; junk on cycles that do not follow a read.
  always @(posedge clk) code_rdata <= code_rd ? mem[code_addr] : CW'($urandom);

  function automatic logic [CW-1:0] cw(input int unsigned p, input int unsigned l,
                                       input logic [CHAR_W-1:0] c);
    code_word_t w;
    w.pos = POS_W'(p);
    w.len = LEN_W'(l);
    w.chr = c;
    return w;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic push(input logic [CW-1:0] w, input int unsigned n);
    for (int i = 0; i < int'(n); i++) exp_q.push_back(w);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (code_rd) rd_cnt++;
      if (done) done_cnt++;
      if (dec_en) begin
        if (en_cnt == 0) en_first = cyc;
        en_last = cyc;
        en_cnt++;
        if (exp_q.size() == 0) begin
          check("dec_unexpected", 32'(dec_en), 32'(0));
        end else begin
          mon_w = exp_q.pop_front();
          check("dec_word", 32'({dec_pos, dec_len, dec_char}), 32'(mon_w));
        end
      end
    end
  end

  task automatic run_case(input string nm, input logic [AW-1:0] a,
                          input int unsigned n_en, input int unsigned span,
                          input int unsigned n_rd, input int unsigned wc,
                          input logic ew, input bit do_stall,
                          input logic [CW-1:0] hold);
    en_cnt = 0; done_cnt = 0; rd_cnt = 0;
    @(posedge clk); #1;
    start_addr = a; start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check({nm, "_rd_t1"}, 32'({code_rd, code_addr}), 32'({1'b1, a}));
    if (do_stall) begin
      for (int k = 0; k < 50 && !dec_en; k++) @(negedge clk);
      check({nm, "_first_en_seen"}, 32'(dec_en), 32'(1));
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check({nm, "_stall_en"}, 32'(dec_en), 32'(0));
        check({nm, "_stall_hold"}, 32'({dec_pos, dec_len, dec_char}), 32'(hold));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    for (int k = 0; k < 200 && !done; k++) @(negedge clk);
    check({nm, "_done"}, 32'({done, busy, err_wrap, word_cnt}), 32'({1'b1, 1'b0, ew, AW'(wc)}));
    repeat (2) @(negedge clk);
    check({nm, "_quiet"}, 32'({done, busy, dec_en}), 32'(0));
    check({nm, "_en_cnt"}, en_cnt, n_en);
    check({nm, "_first_en"}, en_first - t0, 32'(3));
    check({nm, "_span"}, en_last - en_first, span);
    check({nm, "_rd_cnt"}, rd_cnt, n_rd);
    check({nm, "_done_cnt"}, done_cnt, 32'(1));
    check({nm, "_q_empty"}, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    #12;
    check("reset_outs", 32'({code_rd, dec_en, busy, done, err_wrap, word_cnt,
                             dec_pos, dec_len, dec_char, code_addr}), 32'(0));
    @(posedge clk); #1;
    reset = 1'b1;

    // Single literal
    mem[0] = cw(0, 0, END_CHAR);
    push(cw(0, 0, END_CHAR), 1);
    run_case("lit", 2'd0, 1, 0, 1, 1, 1'b0, 1'b0, '0);

    // Match run: 5 cycles of 'a', then '$'
    mem[0] = cw(3, 4, 8'h61); mem[1] = cw(0, 0, END_CHAR);
    push(cw(3, 4, 8'h61), 5); push(cw(0, 0, END_CHAR), 1);
    run_case("match", 2'd0, 6, PF ? 5 : 7, 2, 2, 1'b0, 1'b0, '0);

    // Stall for 3 cycles inside a len=2 word
    mem[0] = cw(5, 2, 8'h62); mem[1] = cw(0, 0, END_CHAR);
    push(cw(5, 2, 8'h62), 3); push(cw(0, 0, END_CHAR), 1);
    run_case("stall", 2'd0, 4, PF ? 6 : 8, 2, 2, 1'b0, 1'b1, cw(5, 2, 8'h62));

    // Address wrap with no '$'
    mem[0] = cw(7, 7, 8'h65); mem[1] = cw(7, 7, 8'h65);
    mem[2] = cw(1, 1, 8'h63); mem[3] = cw(2, 0, 8'h64);
    push(cw(1, 1, 8'h63), 2); push(cw(2, 0, 8'h64), 1);
    run_case("wrap", 2'd2, 3, PF ? 2 : 4, 2, 2, 1'b1, 1'b0, '0);

    // Three words back to back (contiguous with prefetch)
    mem[0] = cw(1, 3, 8'h78); mem[1] = cw(2, 2, 8'h79); mem[2] = cw(0, 0, END_CHAR);
    push(cw(1, 3, 8'h78), 4); push(cw(2, 2, 8'h79), 3); push(cw(0, 0, END_CHAR), 1);
    run_case("seq3", 2'd0, 8, PF ? 7 : 11, 3, 3, 1'b0, 1'b0, '0);

    // Asynchronous reset mid-RUN with the clock stopped
    mem[0] = cw(3, 4, 8'h61); mem[1] = cw(0, 0, END_CHAR);
    push(cw(3, 4, 8'h61), 5);
    en_cnt = 0;
    @(posedge clk); #1;
    start_addr = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 50 && !dec_en; k++) @(negedge clk);
    check("arst_running", 32'(dec_en), 32'(1));
    clk_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_outs", 32'({code_rd, dec_en, busy, done, err_wrap, word_cnt,
                            dec_pos, dec_len, dec_char, code_addr}), 32'(0));
    exp_q.delete();
    #3 reset = 1'b1;
    clk_en = 1'b1;

    // Clean restart after the reset
    mem[0] = cw(0, 0, END_CHAR);
    push(cw(0, 0, END_CHAR), 1);
    run_case("restart", 2'd0, 1, 0, 1, 1, 1'b0, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
